// File: rtl/fade_combiner.sv
// Collects M per-path samples of one channel, sums them into a complex fading
// coefficient and queues {channel, sum} in a small output FIFO.
module fade_combiner #(
    parameter int M     = 8,
    parameter int N     = 32,
    parameter int WIN   = 12,
    parameter int WOUT  = 16,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dv_in,
    input  logic [$clog2(N)-1:0]    chan_in,
    input  logic signed [WIN-1:0]   path_real,
    input  logic signed [WIN-1:0]   path_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(N)-1:0]    out_chan,
    output logic signed [WOUT-1:0]  Zc_real,
    output logic signed [WOUT-1:0]  Zc_imag,
    output logic                    err_seq,
    output logic                    err_ovf,
    output logic                    dbg_state
);
    localparam int CW = $clog2(N);
    localparam int BW = $clog2(M);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t                 state, state_nx;
    logic [BW-1:0]          bcnt, bcnt_nx;
    logic [CW-1:0]          cur_chan, chan_nx;
    logic signed [WOUT-1:0] acc_r, acc_i, acc_r_nx, acc_i_nx;
    logic signed [WOUT-1:0] ext_r, ext_i, sum_r, sum_i;
    logic                   push, seq_hit;

    logic [CW-1:0]          mem_chan [DEPTH];
    logic signed [WOUT-1:0] mem_r [DEPTH];
    logic signed [WOUT-1:0] mem_i [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   pop, push_ok;

    assign ext_r = {{(WOUT-WIN){path_real[WIN-1]}}, path_real};
    assign ext_i = {{(WOUT-WIN){path_imag[WIN-1]}}, path_imag};
    assign sum_r = acc_r + ext_r;
    assign sum_i = acc_i + ext_i;
    assign dbg_state = (state == ACCUM);

    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        chan_nx  = cur_chan;
        acc_r_nx = acc_r;
        acc_i_nx = acc_i;
        push     = 1'b0;
        seq_hit  = 1'b0;
        if (dv_in) begin
            case (state)
                IDLE: begin
                    state_nx = ACCUM;
                    acc_r_nx = ext_r;
                    acc_i_nx = ext_i;
                    chan_nx  = chan_in;
                    bcnt_nx  = BW'(1);
                end
                ACCUM: begin
                    if (chan_in == cur_chan) begin
                        if (bcnt == BW'(M-1)) begin
                            push     = 1'b1;
                            state_nx = IDLE;
                            bcnt_nx  = '0;
                            acc_r_nx = '0;
                            acc_i_nx = '0;
                        end else begin
                            acc_r_nx = sum_r;
                            acc_i_nx = sum_i;
                            bcnt_nx  = bcnt + 1'b1;
                        end
                    end else begin
                        // A channel switch restarts accumulation on the new beat
                        seq_hit  = 1'b1;
                        acc_r_nx = ext_r;
                        acc_i_nx = ext_i;
                        chan_nx  = chan_in;
                        bcnt_nx  = BW'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Handshake: the head entry transfers on any rising edge where
    // out_valid && out_ready; head fields hold while out_valid && !out_ready.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && ((count < (AW+1)'(DEPTH)) || pop);
    assign out_chan  = out_valid ? mem_chan[rd_ptr] : '0;
    assign Zc_real   = out_valid ? mem_r[rd_ptr] : '0;
    assign Zc_imag   = out_valid ? mem_i[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            bcnt     <= '0;
            cur_chan <= '0;
            acc_r    <= '0;
            acc_i    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_seq  <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            state    <= state_nx;
            bcnt     <= bcnt_nx;
            cur_chan <= chan_nx;
            acc_r    <= acc_r_nx;
            acc_i    <= acc_i_nx;
            if (seq_hit)
                err_seq <= 1'b1;
            if (push && !push_ok)
                err_ovf <= 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // At full with a pop, wr_ptr equals rd_ptr: the old head leaves on this edge.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_chan[wr_ptr] <= cur_chan;
            mem_r[wr_ptr]    <= sum_r;
            mem_i[wr_ptr]    <= sum_i;
        end
    end
endmodule

// File: tb/tb_fade_combiner.sv
// Randomized and directed bench for fade_combiner against a queue-based
// model of per-channel path summation and the bounded output FIFO.
module tb_fade_combiner;
    localparam int M = 8, N = 32, WIN = 12, WOUT = 16, DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   dv_in = 1'b0;
    logic [4:0]             chan_in = '0;
    logic signed [WIN-1:0]  path_real = '0;
    logic signed [WIN-1:0]  path_imag = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [4:0]             out_chan;
    logic signed [WOUT-1:0] Zc_real;
    logic signed [WOUT-1:0] Zc_imag;
    logic                   err_seq;
    logic                   err_ovf;
    logic                   dbg_state;

    fade_combiner #(.M(M), .N(N), .WIN(WIN), .WOUT(WOUT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .dv_in(dv_in), .chan_in(chan_in),
        .path_real(path_real), .path_imag(path_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .Zc_real(Zc_real), .Zc_imag(Zc_imag),
        .err_seq(err_seq), .err_ovf(err_ovf), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending outputs, the current partial sequence, sticky flags
    logic [36:0] exp_q[$];
    int          part_r[$];
    int          part_i[$];
    int          part_chan = 0;
    bit          exp_seq = 0;
    bit          exp_ovf = 0;
    bit          sb_on = 0;

    task automatic model_beat(input int ch, input int r, input int i);
        int          sr, si;
        logic [36:0] e;
        logic [15:0] tr, ti;
        logic [4:0]  tc;
        if (part_r.size() != 0 && ch != part_chan) begin
            exp_seq = 1;
            part_r.delete();
            part_i.delete();
        end
        part_chan = ch;
        part_r.push_back(r);
        part_i.push_back(i);
        if (part_r.size() == M) begin
            sr = 0;
            si = 0;
            foreach (part_r[k]) begin
                sr += part_r[k];
                si += part_i[k];
            end
            tc = ch[4:0];
            tr = sr[15:0];
            ti = si[15:0];
            e  = {tc, tr, ti};
            if (exp_q.size() < DEPTH)
                exp_q.push_back(e);
            else
                exp_ovf = 1;
            part_r.delete();
            part_i.delete();
        end
    endtask

    // Inputs change #1 after posedge, so at negedge they show what the next edge samples.
    always @(negedge clk) begin
        logic [36:0] h;
        if (sb_on) begin
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                check("out_chan", out_chan, h[36:32]);
                check("zc_real", $signed(Zc_real), $signed(h[31:16]));
                check("zc_imag", $signed(Zc_imag), $signed(h[15:0]));
            end
            check("err_seq", err_seq, exp_seq);
            check("err_ovf", err_ovf, exp_ovf);
        end
        if (!reset) begin
            exp_q.delete();
            part_r.delete();
            part_i.delete();
            exp_seq = 0;
            exp_ovf = 0;
        end else begin
            if (exp_q.size() != 0 && out_ready)
                void'(exp_q.pop_front());
            if (dv_in)
                model_beat(int'(chan_in), int'(path_real), int'(path_imag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int ch, input int r, input int i);
        dv_in     = 1'b1;
        chan_in   = 5'(ch);
        path_real = WIN'(r);
        path_imag = WIN'(i);
        tick();
        dv_in = 1'b0;
    endtask

    task automatic send_chan(input int ch);
        for (int k = 0; k < M; k++)
            send_beat(ch, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        dv_in   = 1'b1;
        chan_in = 5'($urandom_range(0, 31));
        repeat (2) tick();
        reset = 1'b1;
        dv_in = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_zc_real", Zc_real, 0);
        check("rst_zc_imag", Zc_imag, 0);
        check("rst_err_seq", err_seq, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_state", dbg_state, 0);
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ch;
        tick();
        do_reset();
        sb_on = 1;

        // Known ramp on channel 5
        for (int k = 1; k <= M; k++)
            send_beat(5, k, -k);
        check("ramp_valid", out_valid, 1);
        check("ramp_chan", out_chan, 5);
        check("ramp_real", Zc_real, 36);
        check("ramp_imag", Zc_imag, -36);
        drain();

        // Extremes: no wrap
        for (int k = 0; k < M; k++)
            send_beat(1, -2048, -2048);
        check("min_real", Zc_real, -16384);
        check("min_imag", Zc_imag, -16384);
        for (int k = 0; k < M; k++)
            send_beat(2, 2047, 2047);
        check("max_real", Zc_real, 16376);
        check("max_imag", Zc_imag, 16376);
        drain();

        // Short sequence on 3 interrupted by channel 4
        for (int k = 0; k < 5; k++)
            send_beat(3, 100, 100);
        for (int k = 0; k < M; k++)
            send_beat(4, k + 1, 2);
        check("seq_err", err_seq, 1);
        check("seq_chan", out_chan, 4);
        check("seq_real", Zc_real, 36);
        check("seq_imag", Zc_imag, 16);
        drain();

        // Gapped beats over all channels
        do_reset();
        for (int c = 0; c < N; c++)
            for (int k = 0; k < M; k++) begin
                send_beat(c, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
                repeat ($urandom_range(1, 3)) tick();
            end
        drain();
        check("gap_err_seq", err_seq, 0);
        check("gap_err_ovf", err_ovf, 0);

        // Stalled consumer: fifth result dropped
        out_ready = 1'b0;
        for (int c = 10; c < 15; c++)
            send_chan(c);
        check("ovf_flag", err_ovf, 1);
        check("ovf_valid", out_valid, 1);
        check("ovf_head", out_chan, 10);
        drain();

        // Push into a full FIFO while the head pops: no drop
        do_reset();
        out_ready = 1'b0;
        for (int c = 20; c < 24; c++)
            send_chan(c);
        for (int k = 0; k < M - 1; k++)
            send_beat(24, 7, -7);
        out_ready = 1'b1;
        send_beat(24, 7, -7);
        check("full_pop_ovf", err_ovf, 0);
        drain();

        // Reset mid-accumulation leaves no stale contribution
        for (int k = 0; k < 4; k++)
            send_beat(9, 500, 500);
        do_reset();
        for (int k = 0; k < M; k++)
            send_beat(9, 10, -3);
        check("post_rst_chan", out_chan, 9);
        check("post_rst_real", Zc_real, 80);
        check("post_rst_imag", Zc_imag, -24);
        drain();

        // Random mix: gaps, random backpressure, occasional channel switch
        ch = 0;
        for (int b = 0; b < 400; b++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0)
                ch = $urandom_range(0, 31);
            send_beat(ch, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
            if ($urandom_range(0, 3) == 0)
                tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/fade_combiner.md
# fade_combiner

Consumer of the fader's per-path cosine stream. Collects the M path samples the fader emits for each channel, sums them into one complex fading coefficient per channel and queues the result in a small output FIFO with a valid/ready handshake. Sits between the fader and the channel-coefficient consumers (coefficient RAM writer / channel multiplier). Flags malformed input sequences and output overflow.

## Interface

- M, 8: path samples per channel; power of two, 2..16.
- N, 32: number of channels; chan width = log2(N).
- Win, 12: signed width of each input path sample.
- Wout, 16: signed width of output coefficient; must be ≥ Win+log2(M).
- DEPTH, 4: output FIFO entries; power of two.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- dv_in  in  1  input beat valid; no backpressure toward the fader.
- chan_in  in  log2(N)  channel of the beat.
- path_real  in  Win  signed real path sample.
- path_imag  in  Win  signed imaginary path sample.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_chan  out  log2(N)  channel of head result.
- Zc_real  out  Wout  signed sum of M real samples.
- Zc_imag  out  Wout  signed sum of M imaginary samples.
- err_seq  out  1  sticky: channel changed before M beats collected.
- err_ovf  out  1  sticky: completed result dropped, FIFO full.

## Operation

- States: IDLE (no partial sum), ACCUM (1..M-1 beats held). Beat count `bcnt`, latched channel `cur_chan`, accumulators `acc_r`, `acc_i` (Wout bits, sign-extended adds).
- IDLE, dv_in=1: acc ← sign-extended sample, cur_chan ← chan_in, bcnt ← 1, go ACCUM (if M==1 not allowed, so always ACCUM).
- ACCUM, dv_in=1, chan_in==cur_chan: acc ← acc + sample, bcnt+1. When this is beat M (bcnt==M-1): push {cur_chan, acc+sample} to FIFO, return to IDLE.
- ACCUM, dv_in=1, chan_in≠cur_chan: partial sum discarded, err_seq ← 1, beat starts a new accumulation (acc ← sample, cur_chan ← chan_in, bcnt ← 1, stay ACCUM).
- dv_in=0: no change in any state; gaps between beats of one channel are legal.
- Arithmetic: two's complement, sum of M Win-bit values fits Wout by parameter rule; no saturation, no rounding.
- FIFO: push accepted if occupancy<DEPTH, or occupancy==DEPTH with pop in the same cycle. Otherwise result dropped, err_ovf ← 1, accumulator still returns to IDLE.
- Pop when out_valid && out_ready. Head fields stable while out_valid=1 and out_ready=0.
- err_seq, err_ovf cleared only by reset.

## Timing

- Reset (reset=0 at an edge): out_valid=0, out_chan=0, Zc_real=0, Zc_imag=0, err_seq=0, err_ovf=0, FIFO empty, state IDLE, acc=0, bcnt=0. Reset mid-accumulation discards partial sum and FIFO contents; dv_in ignored in reset cycles.
- Latency: M-th beat sampled at edge k → out_valid=1 from cycle after edge k (visible after edge k) when FIFO was empty; otherwise queued behind existing entries.
- Throughput: one beat per cycle sustained; one result per M cycles at full rate, so DEPTH=4 absorbs 4·M cycles of out_ready=0.
- Simultaneous push and pop at full: both occur, occupancy unchanged, no overflow.
- Simultaneous push and pop at empty+1 with head popping: new entry becomes head next cycle, out_valid stays 1.
- Error flags assert the cycle after the offending edge.

## Test plan

- Channel 5, eight beats real=1..8, imag=-1..-8, back-to-back, out_ready=1 → one output: out_chan=5, Zc_real=36, Zc_imag=-36, out_valid one cycle after 8th beat.
- Eight beats of real=imag=-2048 (min) → Zc_real=Zc_imag=-16384; eight beats of 2047 → 16376; no wrap.
- Channel 3, 5 beats, then channel 4 for 8 beats → err_seq=1; single output chan=4 with channel-4 sum only.
- Random dv_in gaps (dv_in=0 1–3 cycles between beats), channels 0..31 in order → 32 outputs, sums match model, err flags 0.
- out_ready=0 while 5 channels complete → first 4 queued in order, 5th dropped, err_ovf=1; release out_ready → 4 outputs in order, then out_valid=0.
- Assert reset=0 after 4 beats of a channel → all outputs zero; next full 8-beat channel produces correct sum with no stale contribution.
